// File: rtl/bias_add_stage.sv
// bias_add_stage
//
// Streams two's-complement accumulator results in output-channel order, adds a
// per-channel sign-magnitude bias from a writable bank, then applies an
// arithmetic rescale shift, optional ReLU and saturation to DATA_W bits.
//
// Two-register pipeline with valid/ready flow control:
//   stage 1 : bias lookup + widened add        (s1_*_q)
//   stage 2 : shift / ReLU / saturate          (out_*_q)
// Both stages advance together when the output register is empty or being
// drained; otherwise every stage register holds, so nothing is lost or
// duplicated under backpressure.

module bias_add_stage #(
    parameter  int DATA_W  = 16,
    parameter  int ACC_W   = 24,
    parameter  int N_CH    = 16,
    parameter  int SHIFT   = 0,
    parameter  int RELU_EN = 1,
    localparam int CH_W    = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              bias_we,
    input  logic [CH_W-1:0]   bias_waddr,
    input  logic [DATA_W-1:0] bias_wdata,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_W-1:0]  in_data,
    input  logic              in_last,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,

    output logic              err_seq
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------

    // One extra bit over the accumulator so accumulator + bias never wraps.
    localparam int SUM_W = ACC_W + 1;

    // Zero-extension width that lifts a DATA_W-1 bit magnitude to SUM_W bits.
    localparam int MAG_PAD = SUM_W - (DATA_W - 1);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    localparam logic [CH_W:0]   N_CH_V  = (CH_W + 1)'(N_CH);

    // Saturation bounds expressed at the sum width.
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{MAG_PAD{1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{MAG_PAD{1'b1}}, {(DATA_W - 1){1'b0}}};

    localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    logic [DATA_W-1:0]       bias_q [N_CH];
    logic [DATA_W-1:0]       bias_d [N_CH];

    logic [CH_W-1:0]         ch_cnt_q,    ch_cnt_d;
    logic                    err_seq_q,   err_seq_d;

    logic                    s1_valid_q,  s1_valid_d;
    logic signed [SUM_W-1:0] s1_sum_q,    s1_sum_d;
    logic [CH_W-1:0]         s1_ch_q,     s1_ch_d;
    logic                    s1_last_q,   s1_last_d;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_W-1:0]       out_data_q,  out_data_d;
    logic [CH_W-1:0]         out_ch_q,    out_ch_d;
    logic                    out_last_q,  out_last_d;

    // ------------------------------------------------------------------
    // Combinational intermediates
    // ------------------------------------------------------------------

    logic                    adv;
    logic                    accept;
    logic                    at_last_ch;

    logic [DATA_W-1:0]       bias_rd;
    logic signed [SUM_W-1:0] bias_mag_ext;
    logic signed [SUM_W-1:0] bias_tc;
    logic signed [SUM_W-1:0] in_ext;
    logic signed [SUM_W-1:0] sum;

    logic signed [SUM_W-1:0] shifted;
    logic [DATA_W-1:0]       act;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------

    // The whole pipe moves when the output slot is free or being taken; the
    // ready path back to the source is therefore purely combinational.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && rst_n;
    assign accept   = in_valid && in_ready;

    // Channel counter and sticky sequence-error flag.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred; blocking '=' is the
        // right assignment inside combinational logic.
        ch_cnt_d   = ch_cnt_q;
        err_seq_d  = err_seq_q;
        at_last_ch = (ch_cnt_q == LAST_CH);

        if (accept) begin
            // in_last must coincide exactly with the final channel slot.
            if (in_last != at_last_ch) begin
                err_seq_d = 1'b1;
            end

            if (in_last || at_last_ch) begin
                ch_cnt_d = '0;
            end else begin
                ch_cnt_d = ch_cnt_q + 1'b1;
            end
        end
    end

    // Bias bank write port; addresses past the last channel are dropped.
    always_comb begin
        bias_d = bias_q;
        if (bias_we && ({1'b0, bias_waddr} < N_CH_V)) begin
            bias_d[bias_waddr] = bias_wdata;
        end
    end

    // Stage 1 datapath: sign-magnitude bias to two's complement, then add.
    always_comb begin
        bias_rd      = bias_q[ch_cnt_q];
        bias_mag_ext = $signed({{MAG_PAD{1'b0}}, bias_rd[DATA_W-2:0]});
        // Negating a zero magnitude yields zero, so negative zero is benign.
        bias_tc      = bias_rd[DATA_W-1] ? -bias_mag_ext : bias_mag_ext;
        in_ext       = $signed({in_data[ACC_W-1], in_data});
        sum          = in_ext + bias_tc;
    end

    // Stage 2 datapath: floor shift, optional ReLU, saturate to DATA_W.
    always_comb begin
        shifted = s1_sum_q >>> SHIFT;

        if ((RELU_EN != 0) && shifted[SUM_W-1]) begin
            act = '0;
        end else if (shifted > SAT_MAX) begin
            act = OUT_MAX;
        end else if (shifted < SAT_MIN) begin
            act = OUT_MIN;
        end else begin
            act = shifted[DATA_W-1:0];
        end
    end

    // Pipeline register next-state: all stages load together or all hold.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_ch_d     = s1_ch_q;
        s1_last_d   = s1_last_q;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;

        if (adv) begin
            // Bubbles travel as valid=0; payload only moves with a real beat.
            s1_valid_d = accept;
            if (accept) begin
                s1_sum_d  = sum;
                s1_ch_d   = ch_cnt_q;
                s1_last_d = in_last;
            end

            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = act;
                out_ch_d   = s1_ch_q;
                out_last_d = s1_last_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking '<=' so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the bias bank is a small register file that must read as
            // zero after reset, so it is cleared here rather than left to
            // power-up contents as a RAM would be.
            for (int i = 0; i < N_CH; i++) begin
                bias_q[i] <= '0;
            end
            ch_cnt_q    <= '0;
            err_seq_q   <= 1'b0;

            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_ch_q     <= '0;
            s1_last_q   <= 1'b0;

            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            bias_q      <= bias_d;
            ch_cnt_q    <= ch_cnt_d;
            err_seq_q   <= err_seq_d;

            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_ch_q     <= s1_ch_d;
            s1_last_q   <= s1_last_d;

            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign err_seq   = err_seq_q;

endmodule

// File: tb/tb_bias_add_stage.sv
// Directed bench for bias_add_stage. Three instances share all inputs:
//   a : SHIFT=0, RELU_EN=1   (default configuration)
//   b : SHIFT=0, RELU_EN=0
//   c : SHIFT=2, RELU_EN=0
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// there too, away from the active edge.

module tb_bias_add_stage;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 24;
    localparam int N_CH   = 16;
    localparam int CH_W   = $clog2(N_CH);

    logic              clk;
    logic              rst_n;
    logic              bias_we;
    logic [CH_W-1:0]   bias_waddr;
    logic [DATA_W-1:0] bias_wdata;
    logic              in_valid;
    logic [ACC_W-1:0]  in_data;
    logic              in_last;
    logic              out_ready;

    logic              a_in_ready, b_in_ready, c_in_ready;
    logic              a_out_valid, b_out_valid, c_out_valid;
    logic [DATA_W-1:0] a_out_data, b_out_data, c_out_data;
    logic [CH_W-1:0]   a_out_ch, b_out_ch, c_out_ch;
    logic              a_out_last, b_out_last, c_out_last;
    logic              a_err_seq, b_err_seq, c_err_seq;

    int total = 0;
    int bad   = 0;

    bias_add_stage #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_CH(N_CH), .SHIFT(0), .RELU_EN(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .bias_we(bias_we), .bias_waddr(bias_waddr), .bias_wdata(bias_wdata),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_ch(a_out_ch), .out_last(a_out_last), .err_seq(a_err_seq)
    );

    bias_add_stage #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_CH(N_CH), .SHIFT(0), .RELU_EN(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .bias_we(bias_we), .bias_waddr(bias_waddr), .bias_wdata(bias_wdata),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_last(b_out_last), .err_seq(b_err_seq)
    );

    bias_add_stage #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_CH(N_CH), .SHIFT(2), .RELU_EN(0)) u_c (
        .clk(clk), .rst_n(rst_n),
        .bias_we(bias_we), .bias_waddr(bias_waddr), .bias_wdata(bias_wdata),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .out_ch(c_out_ch), .out_last(c_out_last), .err_seq(c_err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        bias_we  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write_bias(input logic [CH_W-1:0] addr, input logic [DATA_W-1:0] val);
        bias_we    = 1'b1;
        bias_waddr = addr;
        bias_wdata = val;
        tick();
        bias_we = 1'b0;
    endtask

    task automatic send(input logic [ACC_W-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #1;
        check("send_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int n_in;
        int n_out;
        logic stall_prev;
        logic [DATA_W-1:0] held_data;
        logic [CH_W-1:0]   held_ch;
        logic              held_last;

        rst_n      = 1'b0;
        bias_we    = 1'b0;
        bias_waddr = '0;
        bias_wdata = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_in_ready",  32'(a_in_ready),  32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data",  32'(a_out_data),  32'd0);
        check("rst_out_ch",    32'(a_out_ch),    32'd0);
        check("rst_out_last",  32'(a_out_last),  32'd0);
        check("rst_err_seq",   32'(a_err_seq),   32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(a_in_ready), 32'd1);

        // ---------------- basic add ----------------
        write_bias(4'd0, 16'h021B);   // +539
        write_bias(4'd1, 16'h8021);   // -33
        send(24'd1000, 1'b0);
        send(24'd10, 1'b0);
        check("basic_ch0_valid", 32'(a_out_valid), 32'd1);
        check("basic_ch0_a",     32'(a_out_data),  32'h0603);  // 1539
        check("basic_ch0_ch",    32'(a_out_ch),    32'd0);
        check("basic_ch0_b",     32'(b_out_data),  32'h0603);
        check("basic_ch0_c",     32'(c_out_data),  32'h0180);  // 1539>>>2 = 384
        tick();
        check("basic_ch1_a",     32'(a_out_data),  32'h0000);  // -23 -> ReLU
        check("basic_ch1_ch",    32'(a_out_ch),    32'd1);
        check("basic_ch1_b",     32'(b_out_data),  32'hFFE9);  // -23
        check("basic_ch1_c",     32'(c_out_data),  32'hFFFA);  // floor(-23/4) = -6
        tick();
        check("basic_bubble",    32'(a_out_valid), 32'd0);

        // ---------------- saturation and negative zero ----------------
        do_reset();
        write_bias(4'd0, 16'h021B);
        write_bias(4'd1, 16'h82CF);   // -719
        write_bias(4'd2, 16'h8000);   // negative zero
        send(24'd40000, 1'b0);
        tick();
        check("sat_pos_a", 32'(a_out_data), 32'h7FFF);
        check("sat_pos_b", 32'(b_out_data), 32'h7FFF);
        check("sat_pos_c", 32'(c_out_data), 32'h2796);      // 40539>>>2 = 10134
        send(24'(-40000), 1'b0);
        tick();
        check("sat_neg_a", 32'(a_out_data), 32'h0000);
        check("sat_neg_b", 32'(b_out_data), 32'h8000);
        check("sat_neg_c", 32'(c_out_data), 32'hD83C);      // floor(-40719/4) = -10180
        send(24'd5, 1'b0);
        tick();
        check("negzero_a", 32'(a_out_data), 32'h0005);
        check("negzero_b", 32'(b_out_data), 32'h0005);
        check("negzero_c", 32'(c_out_data), 32'h0001);

        // ---------------- shift rounding ----------------
        do_reset();
        send(24'(-7), 1'b0);
        tick();
        check("shift_a", 32'(a_out_data), 32'h0000);
        check("shift_b", 32'(b_out_data), 32'hFFF9);
        check("shift_c", 32'(c_out_data), 32'hFFFE);

        // ---------------- backpressure stream ----------------
        do_reset();
        n_in       = 0;
        n_out      = 0;
        stall_prev = 1'b0;
        held_data  = '0;
        held_ch    = '0;
        held_last  = 1'b0;
        for (int cyc = 0; cyc < 200 && n_out < 18; cyc++) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            in_valid  = (n_in < 18);
            in_data   = ACC_W'(1000 + n_in);
            in_last   = (n_in == 15);
            #1;
            if (stall_prev) begin
                check("bp_hold_valid", 32'(a_out_valid), 32'd1);
                check("bp_hold_data",  32'(a_out_data),  32'(held_data));
                check("bp_hold_ch",    32'(a_out_ch),    32'(held_ch));
                check("bp_hold_last",  32'(a_out_last),  32'(held_last));
            end
            check("bp_in_ready", 32'(a_in_ready), 32'(!(a_out_valid && !out_ready)));
            if (a_out_valid && out_ready) begin
                check("bp_data", 32'(a_out_data), 32'(1000 + n_out));
                check("bp_ch",   32'(a_out_ch),   32'(n_out % 16));
                check("bp_last", 32'(a_out_last), 32'(n_out == 15));
                n_out++;
            end
            stall_prev = a_out_valid && !out_ready;
            held_data  = a_out_data;
            held_ch    = a_out_ch;
            held_last  = a_out_last;
            if (in_valid && a_in_ready) begin
                n_in++;
            end
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check("bp_beats_out", 32'(n_out), 32'd18);
        check("bp_no_err",    32'(a_err_seq), 32'd0);

        // ---------------- sequence error: early last ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(ACC_W'(i), 1'b0);
        end
        check("seq_before_err", 32'(a_err_seq), 32'd0);
        send(24'd5, 1'b1);
        check("seq_err_set", 32'(a_err_seq), 32'd1);
        tick();
        check("seq_ch5_ch",   32'(a_out_ch),   32'd5);
        check("seq_ch5_last", 32'(a_out_last), 32'd1);
        tick();
        send(24'd77, 1'b0);
        tick();
        check("seq_next_ch",   32'(a_out_ch),   32'd0);
        check("seq_next_data", 32'(a_out_data), 32'd77);
        tick();
        tick();
        check("seq_err_sticky", 32'(a_err_seq), 32'd1);

        // ---------------- sequence error: missing last at final channel ----------------
        do_reset();
        check("seq2_err_cleared", 32'(a_err_seq), 32'd0);
        for (int i = 0; i < 15; i++) begin
            send(ACC_W'(i), 1'b0);
        end
        check("seq2_before", 32'(a_err_seq), 32'd0);
        send(24'd15, 1'b0);
        check("seq2_err_set", 32'(a_err_seq), 32'd1);
        send(24'd9, 1'b0);
        tick();
        check("seq2_wrap_ch",   32'(a_out_ch),   32'd0);
        check("seq2_wrap_data", 32'(a_out_data), 32'd9);

        // ---------------- reset mid-stream ----------------
        do_reset();
        out_ready = 1'b0;
        send(24'd1, 1'b0);
        send(24'd2, 1'b0);
        check("mid_held_valid", 32'(a_out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("mid_bubble1", 32'(a_out_valid), 32'd0);
        tick();
        check("mid_bubble2", 32'(a_out_valid), 32'd0);
        send(24'd7, 1'b0);
        tick();
        check("mid_next_valid", 32'(a_out_valid), 32'd1);
        check("mid_next_ch",    32'(a_out_ch),    32'd0);
        check("mid_next_data",  32'(a_out_data),  32'd7);

        // ---------------- bias write colliding with accept ----------------
        do_reset();
        bias_we    = 1'b1;
        bias_waddr = 4'd0;
        bias_wdata = 16'd100;
        in_valid   = 1'b1;
        in_data    = 24'd1;
        in_last    = 1'b0;
        #1;
        check("coll_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        bias_we  = 1'b0;
        in_valid = 1'b0;
        tick();
        check("coll_old_a", 32'(a_out_data), 32'd1);
        check("coll_old_c", 32'(c_out_data), 32'd0);
        for (int i = 1; i < 16; i++) begin
            send(24'd0, (i == 15));
        end
        send(24'd1, 1'b0);
        tick();
        check("coll_new_ch", 32'(a_out_ch),   32'd0);
        check("coll_new_a",  32'(a_out_data), 32'd101);
        check("coll_new_b",  32'(b_out_data), 32'd101);
        check("coll_new_c",  32'(c_out_data), 32'd25);
        check("coll_no_err", 32'(a_err_seq),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
